// File: rtl/core_pkg.sv
// Shared core definitions: scheduler state encoding, fetcher handshake
// constant and per-thread LSU state encodings, plus an LSU busy helper.
package core_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_REQUEST = 4'd3,
        S_WAIT    = 4'd4,
        S_EXECUTE = 4'd5,
        S_UPDATE  = 4'd6,
        S_DONE    = 4'd7,
        S_SELECT  = 4'd8
    } core_state_e;

    localparam logic [2:0] FETCHED = 3'b010;

    localparam logic [1:0] LSU_IDLE       = 2'b00;
    localparam logic [1:0] LSU_REQUESTING = 2'b01;
    localparam logic [1:0] LSU_WAITING    = 2'b10;
    localparam logic [1:0] LSU_DONE       = 2'b11;

    function automatic logic lsu_busy(input logic [1:0] s);
        logic b;
        b = 1'b0;
        case (s)
            LSU_REQUESTING, LSU_WAITING: b = 1'b1;
            LSU_IDLE, LSU_DONE:          b = 1'b0;
            default:                     b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/warp_scheduler_if.sv
// Scheduler bus: block control, fetch/decode/LSU status in, state out.
// master = core/testbench side, slave = warp_scheduler.
interface warp_scheduler_if #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
);
    localparam int CW = $clog2(THREADS_PER_BLOCK) + 1;

    logic                                 start;
    logic [CW-1:0]                        thread_count;
    logic [2:0]                           fetcher_state;
    logic                                 decoded_mem_read_enable;
    logic                                 decoded_mem_write_enable;
    logic                                 decoded_ret;
    logic [2*THREADS_PER_BLOCK-1:0]       lsu_state;
    logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc;
    logic [3:0]                           core_state;
    logic [PC_BITS-1:0]                   current_pc;
    logic [THREADS_PER_BLOCK-1:0]         thread_mask;
    logic                                 done;

    modport master (
        output start, thread_count, fetcher_state,
        output decoded_mem_read_enable, decoded_mem_write_enable,
        output decoded_ret, lsu_state, next_pc,
        input  core_state, current_pc, thread_mask, done
    );

    modport slave (
        input  start, thread_count, fetcher_state,
        input  decoded_mem_read_enable, decoded_mem_write_enable,
        input  decoded_ret, lsu_state, next_pc,
        output core_state, current_pc, thread_mask, done
    );

endinterface

// File: rtl/warp_scheduler_pc_min_select.sv
// pc_min_select: combinational minimum-PC search over active threads.
// Ports: i_active (thread mask), i_pcs (packed PCs) -> min_pc, match_mask.
module pc_min_select #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic [THREADS_PER_BLOCK-1:0]         i_active,
    input  logic [THREADS_PER_BLOCK*PC_BITS-1:0] i_pcs,
    output logic [PC_BITS-1:0]                   min_pc,
    output logic [THREADS_PER_BLOCK-1:0]         match_mask
);
    logic w_found;

    always_comb begin
        w_found    = 1'b0;
        min_pc     = '0;
        match_mask = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (i_active[i] &&
                (!w_found || i_pcs[i*PC_BITS +: PC_BITS] < min_pc)) begin
                min_pc  = i_pcs[i*PC_BITS +: PC_BITS];
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            match_mask[i] = i_active[i] &&
                            (i_pcs[i*PC_BITS +: PC_BITS] == min_pc);
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// warp_scheduler: per-core block scheduler FSM (fetch/decode/mem/update).
// Ports: clk, reset (async active-low), bus (warp_scheduler_if.slave).
// Macro WARP_DIVERGENCE_EN: per-thread PCs with min-PC reconvergence.
module warp_scheduler
    import core_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    warp_scheduler_if.slave      bus
);
    localparam int T = THREADS_PER_BLOCK;

    core_state_e        r_state;
    logic [T-1:0]       r_enabled;
    logic [T-1:0]       r_mask;
    logic [PC_BITS-1:0] r_current_pc;

    logic [T-1:0]       w_en_new;
    logic               w_busy;
    logic [T-1:0]       w_active;
    logic [PC_BITS-1:0] w_min_pc;
    logic [T-1:0]       w_match;
    logic               w_unused_mem;

    // memory enables do not alter the fixed REQUEST/WAIT sequence
    assign w_unused_mem = bus.decoded_mem_read_enable ^
                          bus.decoded_mem_write_enable;

`ifdef WARP_DIVERGENCE_EN
    logic [T-1:0][PC_BITS-1:0] r_pc;
    logic [T-1:0]              r_retired;
    logic [T-1:0]              w_retired_nxt;

    assign w_active      = r_enabled & ~r_retired;
    assign w_retired_nxt = r_retired | (bus.decoded_ret ? r_mask : '0);

    pc_min_select #(
        .THREADS_PER_BLOCK (T),
        .PC_BITS           (PC_BITS)
    ) u_min (
        .i_active   (w_active),
        .i_pcs      (r_pc),
        .min_pc     (w_min_pc),
        .match_mask (w_match)
    );
`else
    // one-hot lowest enabled thread: its next_pc drives the shared PC
    assign w_active = r_enabled & (~r_enabled + T'(1));

    pc_min_select #(
        .THREADS_PER_BLOCK (T),
        .PC_BITS           (PC_BITS)
    ) u_min (
        .i_active   (w_active),
        .i_pcs      (bus.next_pc),
        .min_pc     (w_min_pc),
        .match_mask (w_match)
    );
`endif

    always_comb begin
        w_en_new = '0;
        for (int i = 0; i < T; i++) begin
            w_en_new[i] = (i < int'(bus.thread_count));
        end
    end

    // only masked threads can stall WAIT
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < T; i++) begin
            if (r_mask[i] && lsu_busy(bus.lsu_state[2*i +: 2])) begin
                w_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_enabled    <= '0;
            r_mask       <= '0;
            r_current_pc <= '0;
`ifdef WARP_DIVERGENCE_EN
            r_pc         <= '0;
            r_retired    <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_enabled    <= w_en_new;
                        r_current_pc <= '0;
                        r_mask       <= '0;
`ifdef WARP_DIVERGENCE_EN
                        r_pc         <= '0;
                        r_retired    <= '0;
`endif
                        r_state <= (w_en_new == '0) ? S_DONE : S_SELECT;
                    end
                end
                S_SELECT: begin
`ifdef WARP_DIVERGENCE_EN
                    r_current_pc <= w_min_pc;
                    r_mask       <= w_match;
`else
                    r_mask       <= r_enabled;
`endif
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.fetcher_state == FETCHED) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE:  r_state <= S_REQUEST;
                S_REQUEST: r_state <= S_WAIT;
                S_WAIT: begin
                    if (!w_busy) begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: r_state <= S_UPDATE;
                S_UPDATE: begin
`ifdef WARP_DIVERGENCE_EN
                    for (int i = 0; i < T; i++) begin
                        if (r_mask[i] && !bus.decoded_ret) begin
                            r_pc[i] <= bus.next_pc[i*PC_BITS +: PC_BITS];
                        end
                    end
                    r_retired <= w_retired_nxt;
                    if ((w_retired_nxt & r_enabled) == r_enabled) begin
                        r_state <= S_DONE;
                        r_mask  <= '0;
                    end else begin
                        r_state <= S_SELECT;
                    end
`else
                    if (|w_match) begin
                        r_current_pc <= w_min_pc;
                    end
                    if (bus.decoded_ret) begin
                        r_state <= S_DONE;
                        r_mask  <= '0;
                    end else begin
                        r_state <= S_FETCH;
                    end
`endif
                end
                S_DONE: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_state  = r_state;
    assign bus.current_pc  = r_current_pc;
    assign bus.thread_mask = r_mask;
    assign bus.done        = (r_state == S_DONE);

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: vector table, directed
// corner sequences and randomized blocks against a thread-level model.
module tb_warp_scheduler;
    import core_pkg::*;

    localparam int T  = 4;
    localparam int PB = 8;
    localparam int CW = $clog2(T) + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    warp_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) bus ();

    warp_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // thread-level model
    logic [T-1:0]  m_en;
    logic [T-1:0]  m_mask;
    logic [PB-1:0] m_cur;
    logic [PB-1:0] m_pc [T];
    bit            m_ret [T];

    typedef struct {
        int           tc;
        logic [T-1:0] mask;
        bit           dn;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n                        = 1'b0;
        bus.start                    = 1'b0;
        bus.thread_count             = '0;
        bus.fetcher_state            = 3'b000;
        bus.decoded_mem_read_enable  = 1'b0;
        bus.decoded_mem_write_enable = 1'b0;
        bus.decoded_ret              = 1'b0;
        bus.lsu_state                = '0;
        bus.next_pc                  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // min PC over live threads and the group sitting at it
    function automatic void model_select();
        int best;
        best   = -1;
        m_mask = '0;
        for (int i = 0; i < T; i++)
            if (m_en[i] && !m_ret[i] && (best < 0 || int'(m_pc[i]) < best))
                best = int'(m_pc[i]);
        for (int i = 0; i < T; i++)
            if (m_en[i] && !m_ret[i] && int'(m_pc[i]) == best)
                m_mask[i] = 1'b1;
        if (best >= 0) m_cur = PB'(best);
    endfunction

    task automatic set_lsu(input bit busy);
        logic [2*T-1:0] v;
        int idx;
        v = '0;
        for (int i = 0; i < T; i++) begin
            if (m_mask[i]) v[2*i +: 2] = $urandom_range(0, 1) ? LSU_DONE : LSU_IDLE;
            else           v[2*i +: 2] = 2'($urandom_range(0, 3));
        end
        if (busy) begin
            idx = $urandom_range(0, T - 1);
            while (!m_mask[idx]) idx = (idx + 1) % T;
            v[2*idx +: 2] = $urandom_range(0, 1) ? LSU_WAITING : LSU_REQUESTING;
        end
        bus.lsu_state = v;
    endtask

    task automatic begin_block(input int tc, output bit fin);
        int n;
        bus.thread_count = CW'(tc);
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        n    = (tc < T) ? tc : T;
        m_en = T'((1 << n) - 1);
        for (int i = 0; i < T; i++) begin
            m_pc[i]  = '0;
            m_ret[i] = 1'b0;
        end
        if (n == 0) begin
            chk("start_zero_state", bus.core_state, S_DONE);
            chk("start_zero_done", bus.done, 1'b1);
            fin = 1'b1;
            return;
        end
        chk("start_state", bus.core_state, S_SELECT);
        chk("pre_select_mask", bus.thread_mask, '0);
        tick();
        m_mask = m_en;
        m_cur  = '0;
        chk("first_fetch_state", bus.core_state, S_FETCH);
        chk("first_mask", bus.thread_mask, m_mask);
        chk("first_pc", bus.current_pc, m_cur);
        fin = 1'b0;
    endtask

    task automatic do_instr(input int fdelay, input int wdelay,
                            input logic [T*PB-1:0] npc, input bit ret,
                            input bit fix, input logic [2*T-1:0] fixv,
                            output bit fin);
        bit all;
        int fv;
        for (int j = 0; j < fdelay; j++) begin
            fv = $urandom_range(0, 6);
            if (fv >= 2) fv++;
            bus.fetcher_state = 3'(fv);
            tick();
            chk("fetch_hold", bus.core_state, S_FETCH);
        end
        bus.fetcher_state = FETCHED;
        tick();
        chk("decode", bus.core_state, S_DECODE);
        bus.fetcher_state = 3'b000;
        tick();
        chk("request", bus.core_state, S_REQUEST);
        tick();
        chk("wait_enter", bus.core_state, S_WAIT);
        for (int j = 0; j < wdelay; j++) begin
            if (fix) bus.lsu_state = fixv;
            else     set_lsu(1'b1);
            tick();
            chk("wait_hold", bus.core_state, S_WAIT);
        end
        set_lsu(1'b0);
        tick();
        chk("execute", bus.core_state, S_EXECUTE);
        bus.lsu_state = 2*T'($urandom);
        tick();
        chk("update", bus.core_state, S_UPDATE);
        bus.next_pc                  = npc;
        bus.decoded_ret              = ret;
        bus.decoded_mem_read_enable  = 1'($urandom);
        bus.decoded_mem_write_enable = 1'($urandom);
        tick();
        bus.decoded_ret = 1'b0;
`ifdef WARP_DIVERGENCE_EN
        for (int i = 0; i < T; i++) begin
            if (m_mask[i]) begin
                if (ret) m_ret[i] = 1'b1;
                else     m_pc[i]  = npc[i*PB +: PB];
            end
        end
        all = 1'b1;
        for (int i = 0; i < T; i++) if (m_en[i] && !m_ret[i]) all = 1'b0;
        if (all) begin
            chk("done_state", bus.core_state, S_DONE);
            chk("done_flag", bus.done, 1'b1);
            chk("done_mask", bus.thread_mask, '0);
            fin = 1'b1;
        end else begin
            chk("select_state", bus.core_state, S_SELECT);
            chk("select_mask_hold", bus.thread_mask, m_mask);
            tick();
            model_select();
            chk("sel_fetch", bus.core_state, S_FETCH);
            chk("sel_pc", bus.current_pc, m_cur);
            chk("sel_mask", bus.thread_mask, m_mask);
            fin = 1'b0;
        end
`else
        all = ret;
        if (all) begin
            chk("done_state", bus.core_state, S_DONE);
            chk("done_flag", bus.done, 1'b1);
            chk("done_mask", bus.thread_mask, '0);
            fin = 1'b1;
        end else begin
            m_cur = npc[PB-1:0];
            chk("next_fetch", bus.core_state, S_FETCH);
            chk("next_pc", bus.current_pc, m_cur);
            chk("next_mask", bus.thread_mask, m_en);
            fin = 1'b0;
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fin;
        logic [T*PB-1:0] npc;
        int k;
        int tc;

        tbl[0] = '{0, 4'b0000, 1'b1};
        tbl[1] = '{1, 4'b0001, 1'b0};
        tbl[2] = '{2, 4'b0011, 1'b0};
        tbl[3] = '{3, 4'b0111, 1'b0};
        tbl[4] = '{4, 4'b1111, 1'b0};
        tbl[5] = '{7, 4'b1111, 1'b0};

        do_reset();
        chk("rst_state", bus.core_state, S_IDLE);
        chk("rst_pc", bus.current_pc, '0);
        chk("rst_mask", bus.thread_mask, '0);
        chk("rst_done", bus.done, 1'b0);
        repeat (3) tick();
        chk("idle_hold", bus.core_state, S_IDLE);

        // thread_count table
        foreach (tbl[v]) begin
            do_reset();
            bus.thread_count = CW'(tbl[v].tc);
            bus.start        = 1'b1;
            tick();
            bus.start = 1'b0;
            chk("tbl_done", bus.done, tbl[v].dn);
            if (tbl[v].dn) begin
                bus.start        = 1'b1;
                bus.thread_count = CW'(4);
                repeat (3) tick();
                bus.start = 1'b0;
                chk("tbl_done_sticky", bus.core_state, S_DONE);
                chk("tbl_done_mask", bus.thread_mask, '0);
            end else begin
                tick();
                chk("tbl_mask", bus.thread_mask, tbl[v].mask);
            end
        end

        // four threads, three instructions then RET
        do_reset();
        begin_block(4, fin);
        for (int i = 0; i < 3; i++) begin
            npc = {4{PB'(i + 1)}};
            do_instr(2, 0, npc, 1'b0, 1'b0, '0, fin);
            chk("seq_mask", bus.thread_mask, 4'b1111);
        end
        do_instr(2, 0, '0, 1'b1, 1'b0, '0, fin);
        chk("seq_final_done", bus.done, 1'b1);

        // masked t2 waiting 5 cycles, unmasked t3 busy
        do_reset();
        begin_block(3, fin);
        chk("stall_mask", bus.thread_mask, 4'b0111);
        do_instr(0, 5, '0, 1'b1, 1'b1,
                 {LSU_WAITING, LSU_WAITING, LSU_IDLE, LSU_IDLE}, fin);

`ifdef WARP_DIVERGENCE_EN
        do_reset();
        begin_block(4, fin);
        do_instr(1, 1, {8'd9, 8'd9, 8'd5, 8'd5}, 1'b0, 1'b0, '0, fin);
        chk("div_pc5", bus.current_pc, 8'd5);
        chk("div_mask5", bus.thread_mask, 4'b0011);
        do_instr(1, 0, {8'd1, 8'd1, 8'd9, 8'd9}, 1'b0, 1'b0, '0, fin);
        chk("div_pc9", bus.current_pc, 8'd9);
        chk("div_mask9", bus.thread_mask, 4'b1111);
        do_instr(0, 0, '0, 1'b1, 1'b0, '0, fin);
`else
        do_reset();
        begin_block(4, fin);
        do_instr(1, 1, {8'd8, 8'd8, 8'd8, 8'd3}, 1'b0, 1'b0, '0, fin);
        chk("uni_pc3", bus.current_pc, 8'd3);
        chk("uni_mask", bus.thread_mask, 4'b1111);
        do_instr(0, 0, '0, 1'b1, 1'b0, '0, fin);
`endif

        // asynchronous reset in WAIT with LSUs busy
        do_reset();
        begin_block(4, fin);
        bus.fetcher_state = FETCHED;
        repeat (3) tick();
        bus.fetcher_state = 3'b000;
        bus.lsu_state = {T{LSU_WAITING}};
        tick();
        chk("areset_pre", bus.core_state, S_WAIT);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_state", bus.core_state, S_IDLE);
        chk("areset_pc", bus.current_pc, '0);
        chk("areset_mask", bus.thread_mask, '0);
        chk("areset_done", bus.done, 1'b0);
        tick();
        rst_n = 1'b1;
        bus.lsu_state = '0;
        tick();
        chk("areset_idle", bus.core_state, S_IDLE);
        begin_block(2, fin);
        do_instr(0, 0, '0, 1'b1, 1'b0, '0, fin);

        // randomized blocks
        for (int b = 0; b < 8; b++) begin
            do_reset();
            tc = $urandom_range(1, 7);
            begin_block(tc, fin);
            k = 0;
            while (!fin && k < 40) begin
                for (int i = 0; i < T; i++) npc[i*PB +: PB] = PB'($urandom);
                do_instr($urandom_range(0, 3), $urandom_range(0, 3), npc,
                         (k >= 4) || ($urandom_range(0, 3) == 0),
                         1'b0, '0, fin);
                k++;
            end
            chk("rand_block_finish", fin, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 Parameters SHALL be THREADS_PER_BLOCK, default 4, the thread slots per core; and PC_BITS, default 8, the program counter width.
REQ-002 clk  in  1  core clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  level; begins block execution when sampled high in IDLE.
REQ-005 thread_count  in  $clog2(THREADS_PER_BLOCK)+1  number of enabled threads, latched at start.
REQ-006 fetcher_state  in  3  fetcher FSM state; FETCHED = 3'b010.
REQ-007 decoded_mem_read_enable, decoded_mem_write_enable, decoded_ret  in  1 each  decoded control.
REQ-008 lsu_state  in  2*THREADS_PER_BLOCK  per-thread LSU state, thread i at bits [2i+1:2i]: 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE.
REQ-009 next_pc  in  PC_BITS*THREADS_PER_BLOCK  per-thread next PC, thread i at slice i.
REQ-010 core_state  out  4  scheduler state, broadcast to datapath.
REQ-011 current_pc  out  PC_BITS  PC of the active thread group.
REQ-012 thread_mask  out  THREADS_PER_BLOCK  threads executing the current instruction.
REQ-013 done  out  1  all enabled threads retired.

Function
REQ-014 The state encodings SHALL be IDLE 0, FETCH 1, DECODE 2, REQUEST 3, WAIT 4, EXECUTE 5, UPDATE 6, DONE 7, SELECT 8.
REQ-015 In IDLE with start=1, the block SHALL latch enabled = (i < min(thread_count, THREADS_PER_BLOCK)), clear retired flags and per-thread PCs to 0, and go to SELECT; thread_count=0 SHALL go directly to DONE.
REQ-016 FETCH SHALL hold until fetcher_state==FETCHED, then go to DECODE; DECODE->REQUEST->WAIT SHALL each take exactly one cycle.
REQ-017 WAIT SHALL hold while any thread with thread_mask[i]=1 has lsu_state 01 or 10, and go to EXECUTE on the first cycle none does; lsu_state of unmasked threads SHALL be ignored.
REQ-018 EXECUTE->UPDATE SHALL take exactly one cycle.
REQ-019 In UPDATE, each masked thread SHALL capture next_pc[i] into its PC register; if decoded_ret=1, masked threads SHALL instead be marked retired.
REQ-020 From UPDATE, the block SHALL go to DONE if every enabled thread is retired, else to SELECT.
REQ-021 SELECT SHALL, in one cycle, set current_pc to the minimum PC over enabled, non-retired threads and thread_mask to all such threads whose PC equals it, then go to FETCH; threads with equal PCs SHALL reconverge automatically.
REQ-022 In DONE, done SHALL be 1 and the state SHALL hold until reset; start SHALL be ignored.
REQ-023 thread_mask SHALL be 0 in IDLE and DONE, and SHALL change only in SELECT or on entry to DONE.
REQ-024 PC arithmetic SHALL be unsigned; comparison SHALL be full PC_BITS-wide with no wrap handling.

Reset
REQ-025 With reset low, immediately and regardless of clk: core_state=IDLE, current_pc=0, thread_mask=0, done=0, all per-thread PCs 0, all retired flags 0, enabled mask 0.
REQ-026 Reset asserted mid-operation (including WAIT with LSUs busy) SHALL abandon the block; no state SHALL persist.

Configuration
REQ-027 With WARP_DIVERGENCE_EN defined, per-thread PCs and SELECT SHALL behave as in REQ-019 to REQ-021.
REQ-028 Without WARP_DIVERGENCE_EN:
- No per-thread PC registers.
- UPDATE SHALL set current_pc to next_pc of the lowest-index enabled thread.
- thread_mask SHALL equal the enabled mask.
- decoded_ret SHALL retire all threads.
- SELECT SHALL be used only after start; UPDATE SHALL go to FETCH.

Structure
REQ-029 The core_state enum, FETCHED constant and LSU state encodings SHALL live in shared package core_pkg.
REQ-030 The min-PC search SHALL be a combinational sub-module pc_min_select, parametrised by THREADS_PER_BLOCK and PC_BITS, with outputs min_pc and match_mask.

Verification
REQ-031 thread_count=4, three instructions then RET, fetcher FETCHED after 2 cycles -> mask 1111 throughout, done=1 one cycle after final UPDATE.
REQ-032 WARP_DIVERGENCE_EN, UPDATE with next_pc {t0..t3}={5,5,9,9} -> SELECT gives current_pc=5, mask=0011; after t0/t1 reach 9 -> current_pc=9, mask=1111.
REQ-033 Thread 2 masked with lsu_state=10 for 5 cycles, thread 3 unmasked and busy -> WAIT for exactly 5 cycles, EXECUTE on the 6th.
REQ-034 thread_count=0 -> DONE one cycle after start; thread_count=2 -> mask 0011; thread_count=7 with 4 slots -> mask 1111.
REQ-035 reset driven low mid-WAIT between clock edges -> all outputs reset before the next edge.
REQ-036 Macro off, next_pc {3,8,8,8} -> current_pc=3, mask=1111.
